// File: rtl/mem_stage_sram.sv
// Memory stage driving a multi-cycle external SRAM, holding the MEM/WB register
// and freezing the upstream pipeline while an access is in flight.
//
// state  | meaning
// IDLE   | no access; a request freezes upstream and starts ACCESS
// ACCESS | strobes active, counting WAIT_STATES cycles
// DONE   | result presented to MEM/WB; requests still visible are ignored
module mem_stage_sram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 4,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       alu_result_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [3:0]        dest_in,
  output logic              freeze,
  output logic              wb_en,
  output logic              mem_r_en_out,
  output logic [31:0]       alu_result,
  output logic [DATA_W-1:0] mem_read_value,
  output logic [3:0]        dest,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES - 1);
  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic              req;

  assign req       = mem_r_en | mem_w_en;
  assign sram_addr = ADDR_W'((alu_result_in - BASE) >> 2);

  always_comb begin
    state_d    = state_q;
    freeze     = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_wdata = '0;
    case (state_q)
      IDLE: begin
        // Freeze is held off during reset so a stale request cannot stall the pipe
        if (req && rst) begin
          freeze  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        freeze     = 1'b1;
        sram_wdata = st_val_in;
        sram_oe_n  = ~mem_r_en;
        sram_we_n  = ~(mem_w_en & ~mem_r_en);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) hold_q <= sram_rdata;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // MEM/WB register; a frozen cycle inserts a bubble so nothing writes back twice
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en          <= 1'b0;
      mem_r_en_out   <= 1'b0;
      alu_result     <= '0;
      mem_read_value <= '0;
      dest           <= '0;
    end else if (!freeze) begin
      wb_en          <= wb_en_in;
      mem_r_en_out   <= mem_r_en;
      alu_result     <= alu_result_in;
      dest           <= dest_in;
      mem_read_value <= (state_q == DONE) ? hold_q : sram_rdata;
    end else begin
      wb_en        <= 1'b0;
      mem_r_en_out <= 1'b0;
    end
  end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Parametrised successor of the pipeline's single-cycle memory stage: performs loads and stores against an external multi-cycle SRAM with a configurable number of wait states. It holds the MEM/WB pipeline register internally and raises `freeze` to stall every upstream stage while an access is in flight. It sits between the EXE/MEM register and the write-back mux of the 5-stage ARM pipeline.

## Interface
Parameters:
- `DATA_W`, 32: data word width.
- `ADDR_W`, 18: SRAM word-address width.
- `WAIT_STATES`, 4: SRAM access cycles per operation; legal range ≥1.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `wb_en_in`  in  1: write-back enable from EXE/MEM.
- `mem_r_en`  in  1: load request.
- `mem_w_en`  in  1: store request.
- `alu_result_in`  in  32: byte address for a memory operation, otherwise the ALU result.
- `st_val_in`  in  DATA_W: store data.
- `dest_in`  in  4: destination register.
- `freeze`  out  1: stall request to the IF, ID and EXE stages and their registers.
- `wb_en`  out  1: MEM/WB write-back enable.
- `mem_r_en_out`  out  1: MEM/WB load flag; selects `mem_read_value` at write-back.
- `alu_result`  out  32: MEM/WB ALU result.
- `mem_read_value`  out  DATA_W: MEM/WB load data.
- `dest`  out  4: MEM/WB destination register.
- `sram_addr`  out  ADDR_W: SRAM word address.
- `sram_wdata`  out  DATA_W: SRAM write data.
- `sram_rdata`  in  DATA_W: SRAM read data.
- `sram_we_n`  out  1: SRAM write strobe, active-low.
- `sram_oe_n`  out  1: SRAM output enable, active-low.

## Operation
- FSM states:
  - IDLE → ACCESS when `mem_r_en | mem_w_en`. Counter is cleared to 0.
  - ACCESS: the counter increments each cycle. At count == WAIT_STATES-1, load data `sram_rdata` is latched into an internal holding register and the FSM moves to DONE.
  - DONE → IDLE unconditionally. The request inputs are still asserted in DONE, because the upstream register was frozen until this edge; DONE must not restart the access.
- `freeze` is combinational. It is 1 in IDLE when a request is present, 1 in ACCESS, and 0 in DONE and in IDLE without a request.
- `sram_addr = ((alu_result_in - BASE_ADDR) >> 2)[ADDR_W-1:0]`. The subtraction is 32-bit modular and the result is truncated; no range check is performed.
- In ACCESS, `sram_wdata = st_val_in`. In all other states it is 0.
- `sram_we_n` is 0 only in ACCESS for a store. `sram_oe_n` is 0 only in ACCESS for a load.
- If `mem_r_en` and `mem_w_en` are both high, the load wins and no SRAM write occurs.
- MEM/WB register behaviour:
  - When `freeze` = 0, it loads `wb_en_in`, `mem_r_en`, `alu_result_in`, `dest_in`, and load data. Load data is the holding register in DONE, otherwise `sram_rdata`.
  - When `freeze` = 1, it loads a bubble: `wb_en` = 0, `mem_r_en_out` = 0, other fields unchanged. A frozen instruction is therefore never written back twice.
- Non-memory instructions pass through with one-cycle latency and no stall.

## Timing
- Reset (async, `rst` = 0):
  - FSM goes to IDLE and the counter to 0.
  - `wb_en`, `mem_r_en_out`, `alu_result`, `mem_read_value`, `dest` = 0.
  - `sram_we_n` = `sram_oe_n` = 1 and `sram_wdata` = 0 immediately, including when reset occurs mid-access.
  - The aborted access is discarded; no write-back occurs.
- Memory operation, with request visible in cycle 0:
  - `freeze` is high in cycles 0..WAIT_STATES (WAIT_STATES+1 cycles).
  - Strobes are active in cycles 1..WAIT_STATES.
  - DONE is cycle WAIT_STATES+1.
  - MEM/WB presents the result after the edge ending DONE, so total latency is WAIT_STATES+2 cycles.
- Back-to-back memory operations: the next request appears in the cycle after DONE (IDLE) and starts a fresh access. There is no overlap and no lost cycle beyond the DONE cycle.
- `sram_rdata` must be stable at the last ACCESS edge.

## Test plan
- **Reset:** hold `rst` = 0 with `mem_w_en` = 1 → `sram_we_n` = 1, `freeze` = 0, all MEM/WB outputs 0.
- **ALU pass-through:** `wb_en_in` = 1, `alu_result_in` = 0x0000_00A5, `dest_in` = 3, no memory request → next cycle `wb_en` = 1, `alu_result` = 0xA5, `dest` = 3, `freeze` never high.
- **Store then load, WAIT_STATES = 4:**
  - Store 0xDEAD_BEEF to address 1028 → `sram_addr` = 1, `sram_we_n` low for exactly 4 cycles, `freeze` high for 5 cycles, MEM/WB `wb_en` = 0.
  - Load from address 1028 with SRAM model returning 0xDEAD_BEEF → `mem_r_en_out` = 1, `mem_read_value` = 0xDEAD_BEEF, `wb_en` pulses for exactly one cycle.
- **Conflicting request:** `mem_r_en` = `mem_w_en` = 1 → `sram_we_n` stays 1, `sram_oe_n` low for 4 cycles.
- **Reset mid-access:** assert `rst` = 0 in the 2nd ACCESS cycle of a store → `sram_we_n` = 1 within the same cycle, FSM in IDLE after release, no write-back.
- **Back-to-back loads, WAIT_STATES = 1:** two consecutive loads → each freezes 2 cycles, one DONE cycle between them, both values written back in order.
